// File: rtl/panel_row_receiver.sv
// rtl/panel_row_receiver.sv - panel LED row deserializer, latches and row sequencer
// Optional framing check: define PANEL_RX_FRAME_CHECK_EN.
module panel_row_receiver #(
    parameter int WIDTH = 16,
    parameter int ROWS  = 16,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             load_led_vals,
    input  logic             load_brightness,
    input  logic             serial_in_red,
    input  logic             serial_in_green,
    input  logic             serial_in_blue,
    output logic [WIDTH-1:0] led_red,
    output logic [WIDTH-1:0] led_green,
    output logic [WIDTH-1:0] led_blue,
    output logic [7:0]       bright_red,
    output logic [7:0]       bright_green,
    output logic [7:0]       bright_blue,
    output logic [RW-1:0]    row_index,
    output logic             row_valid,
    output logic             frame_done,
    output logic             frame_error
);

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic [WIDTH-1:0] sr_red;
    logic [WIDTH-1:0] sr_green;
    logic [WIDTH-1:0] sr_blue;
    logic [RW-1:0]    row_cnt;

    // Loads sample the pre-edge shift register, so a same-cycle shift
    // bit becomes the first bit of the following word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_red       <= '0;
            sr_green     <= '0;
            sr_blue      <= '0;
            led_red      <= '0;
            led_green    <= '0;
            led_blue     <= '0;
            bright_red   <= '0;
            bright_green <= '0;
            bright_blue  <= '0;
            row_index    <= '0;
            row_cnt      <= '0;
            row_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (shift) begin
                sr_red   <= {sr_red[WIDTH-2:0], serial_in_red};
                sr_green <= {sr_green[WIDTH-2:0], serial_in_green};
                sr_blue  <= {sr_blue[WIDTH-2:0], serial_in_blue};
            end
            if (load_led_vals) begin
                led_red   <= sr_red;
                led_green <= sr_green;
                led_blue  <= sr_blue;
                row_index <= row_cnt;
                row_cnt   <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
            end
            if (load_brightness) begin
                bright_red   <= sr_red[7:0];
                bright_green <= sr_green[7:0];
                bright_blue  <= sr_blue[7:0];
            end
            row_valid  <= load_led_vals;
            frame_done <= load_led_vals && (row_cnt == LAST_ROW);
        end
    end

`ifdef PANEL_RX_FRAME_CHECK_EN
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_WORD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_BYTE = CW'(8);

    logic [CW-1:0] shift_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt   <= '0;
            frame_error <= 1'b0;
        end else begin
            if (load_led_vals || load_brightness) begin
                shift_cnt <= shift ? CW'(1) : '0;
            end else if (shift && shift_cnt != CNT_SAT) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
            if ((load_led_vals && shift_cnt != CNT_WORD) ||
                (load_brightness && shift_cnt < CNT_BYTE)) begin
                frame_error <= 1'b1;
            end
        end
    end
`else
    assign frame_error = 1'b0;
`endif

endmodule

// File: doc/panel_row_receiver.md
# panel_row_receiver

Receiving end of the panel serial LED link: a cycle-accurate model of the panel's row shift-register hardware. Deserializes the red, green and blue serial streams under the shared `shift` strobe, transfers the shift-register contents to output latches on `load_led_vals` / `load_brightness`, and tracks the row sequence. Used as the loopback target in panel-level benches and as a link monitor on the FPGA debug build.

## Interface
- `WIDTH`, 16: LEDs per row, i.e. shift-register length per color (≥ 8)
- `ROWS`, 16: rows per frame; row index wraps at `ROWS`-1
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous reset, active-high
- `shift`  input  1  shift strobe, one bit per color per asserted cycle
- `load_led_vals`  input  1  latch LED on/off vectors
- `load_brightness`  input  1  latch brightness bytes
- `serial_in_red` / `serial_in_green` / `serial_in_blue`  input  1 each  serial data, sampled when `shift`=1
- `led_red` / `led_green` / `led_blue`  output  WIDTH each  latched LED vectors
- `bright_red` / `bright_green` / `bright_blue`  output  8 each  latched brightness
- `row_index`  output  $clog2(ROWS)  row number of the current `led_*` contents
- `row_valid`  output  1  one-cycle pulse after each LED latch
- `frame_done`  output  1  one-cycle pulse when row `ROWS`-1 is latched
- `frame_error`  output  1  sticky framing error (only with `PANEL_RX_FRAME_CHECK_EN`)

## Operation
- Per color, a WIDTH-bit shift register `sr`. On `shift`=1: `sr <= {sr[WIDTH-2:0], serial_in}`, so the first bit shifted lands in the MSB after WIDTH shifts.
- `load_led_vals`=1: `led_* <= sr` (pre-edge contents, excluding any bit shifted in the same cycle). `row_index <=` internal row counter; the counter increments, wrapping `ROWS`-1 → 0. `row_valid` <= 1 next cycle; `frame_done` <= 1 when the latched row is `ROWS`-1.
- `load_brightness`=1: `bright_* <= sr[7:0]` (pre-edge). Row counter unaffected.
- Both loads in one cycle: both latches update from the same `sr`; row counter advances once.
- Shift and load in one cycle: the load takes the old `sr`; the shift still occurs; the new bit counts as bit 1 of the next word.
- Shift registers are not cleared by loads; stale bits persist until shifted out.
- Reset: `sr`, `led_*`, `bright_*` ← 0; `row_index` and row counter ← 0; `row_valid`, `frame_done`, `frame_error` ← 0. Reset mid-word discards partial data; the first load after reset latches row 0.

## Timing
- Input-to-output latency: one clock. Strobe sampled at edge N → `led_*`/`bright_*`/`row_index` valid after edge N, `row_valid`/`frame_done` high for exactly the cycle after edge N.
- Back-to-back `load_led_vals` on consecutive cycles: each latches, each pulses `row_valid`, counter advances twice.
- No handshake or backpressure; all strobes are accepted every cycle.

## Configuration
- `PANEL_RX_FRAME_CHECK_EN` defined: a saturating shift counter (counts shifts since the last load of either kind, saturating at WIDTH+1) is kept. Any `load_led_vals` with count ≠ WIDTH, or `load_brightness` with count < 8, sets `frame_error`; it stays set until `reset`. A shift in the load cycle counts toward the next word.
- Undefined: no counter; `frame_error` tied to 0.

## Test plan
- Reset then shift 16 bits 0xA5C3 (MSB first) on red, 0xFFFF green, 0x0001 blue, pulse `load_led_vals` → next cycle `led_red`=0xA5C3, `led_green`=0xFFFF, `led_blue`=0x0001, `row_index`=0, `row_valid` one cycle.
- 16 complete rows → `row_index` 0..15, `frame_done` only after row 15; 17th row → `row_index`=0.
- Shift 8 bits 0x7E on each color, pulse `load_brightness` → `bright_*`=0x7E, `led_*` and `row_index` unchanged; with check enabled `frame_error`=0.
- `shift` and `load_led_vals` together on the 17th shift → `led_*` holds the first 16 bits; the 17th bit appears in `sr` LSB; subsequent 15 shifts + load give a clean word.
- With `PANEL_RX_FRAME_CHECK_EN`: 15 shifts then `load_led_vals` → `frame_error`=1, stays 1 through further good rows, clears only on `reset`.
- Assert `reset` after 9 of 16 shifts, then shift a full 0x1234 and load → `led_red`=0x1234, `row_index`=0, no `frame_error`.
